qpsk_prbs_checker: RTL and testbench
====================================

// Module: qpsk_prbs_checker
// PURPOSE
//  Downstream of the QPSK modulator. Hard-decides each received I/Q symbol into a bit pair and
//  self-synchronises a local copy of the m-sequence to the recovered bits. Once locked, it
//  compares every bit against the local copy and counts bit errors (BER measurement).
//  Drives the lock and error status used by the sim bench and the board LEDs.
// PARAMETERS
//  LFSR_LEN    5          m-sequence register length (period 2^LFSR_LEN-1 = 31)
//  TAPS        5'b10100   feedback mask; next = ^(shreg & TAPS), i.e. x^5+x^3+1
//  VERIFY_LEN  16         consecutive correct bits needed to declare lock
//  WIN_LEN     64         loss-of-lock observation window, in bits
//  ERR_LIMIT   8          errors within one window that force resync
//  CNT_W       32         width of bit_cnt / err_cnt
// PORTS
//  CLK_50MHZ  in   1      system clock, all logic on rising edge
//  RST_N      in   1      asynchronous active-low reset
//  sym_valid  in   1      dataI/dataQ hold a new symbol this cycle
//  dataI      in   8      I sample, two's complement
//  dataQ      in   8      Q sample, two's complement
//  clr_cnt    in   1      synchronous clear of bit_cnt/err_cnt (lock state kept)
//  rx_bits    out  2      decided pair {bI,bQ}; bI is the earlier bit
//  rx_valid   out  1      rx_bits valid, 1 cycle after sym_valid
//  locked     out  1      FSM in LOCK
//  bit_cnt    out  CNT_W  bits compared while locked, saturating
//  err_cnt    out  CNT_W  mismatching bits while locked, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=SEARCH, shreg=0, verify and window counters 0.
//  - Decision: b = sample[7] (negative -> 1). Registered, so latency is 1 cycle.
//    A cycle without sym_valid drives rx_valid=0 and leaves everything else held.
//  - Each symbol carries 2 bits, processed serially: bI first, then bQ, in one cycle.
//  - FSM:
//    SEARCH: shift both received bits into shreg. Once >=LFSR_LEN bits are collected and
//      shreg != 0, go to VERIFY with verify counter 0. An all-zero shreg stays in SEARCH.
//    VERIFY: predict p=^(shreg&TAPS) and shift p into shreg (local copy, not rx).
//      For each matching bit, verify++. On any mismatch, return to SEARCH with the bit
//      counter cleared. When verify reaches VERIFY_LEN (checked after each bit), go to
//      LOCK. A symbol that straddles the threshold counts its 2nd bit in LOCK.
//    LOCK: prediction as in VERIFY. For each bit, bit_cnt++; on mismatch, err_cnt++.
//      Both saturate at all-ones.
//  - clr_cnt has priority over increments in the same cycle. Counters keep their values
//    across loss of lock; only reset or clr_cnt zeroes them.
//  - Reset asserted mid-operation returns immediately to reset state; no partial lock is kept.
// CONFIGURATION
//  QPSK_CHK_LOSS_DETECT_EN defined:
//    - In LOCK, a window counter runs over WIN_LEN bits with a window error count.
//    - If window errors reach ERR_LIMIT, go to SEARCH at the end of that symbol
//      (locked falls the next cycle), and the window resets.
//    - At window wrap without reaching the limit, the window error count clears.
//  Not defined: LOCK is left only by reset; no window logic is synthesised.
// STRUCTURE
//  - Shared package qpsk_pkg: FSM state localparams (SEARCH=2'd0, VERIFY=2'd1, LOCK=2'd2),
//    the default LFSR_LEN/TAPS, and the sample width 8. The modulator uses the same values.
//  - Sub-module prbs_step: combinational two-bit LFSR advance (shreg in, 2 predicted bits
//    and next shreg out). It is instanced once here and reusable by the modulator generator.
// TESTING
//  1 Reset, then feed the clean 31-bit m-sequence mapped to +/-100 with sym_valid every
//    cycle -> locked=1 within (5+16)/2 symbols (+1 cycle), err_cnt stays 0, and bit_cnt
//    advances by 2 per symbol.
//  2 Locked, then flip dataI sign on exactly 3 symbols -> err_cnt=3, locked stays 1.
//  3 With LOSS_DETECT_EN, locked, then invert 8 bits within 64 -> locked=0 next cycle, and
//    relock after 21 clean bits; err_cnt retains its count.
//  4 Feed all-zero bits (samples +50) for 40 symbols -> stays in SEARCH, locked=0,
//    bit_cnt=0.
//  5 sym_valid toggles every 3rd cycle -> same lock point in symbols as test 1, and no state
//    change on idle cycles.
//  6 Pulse clr_cnt while locked and erroring on the same cycle -> counters read 0 next
//    cycle. Assert RST_N low mid-VERIFY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Values shared by the QPSK modulator and the PRBS checker: sample width, default
// m-sequence generator and the checker FSM encoding.
package qpsk_pkg;

    localparam int         SAMPLE_W     = 8;
    localparam int         LFSR_LEN_DEF = 5;
    localparam logic [4:0] TAPS_DEF     = 5'b10100;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } chk_state_t;

endpackage

// File: rtl/prbs_step.sv
// Combinational two-bit advance of the m-sequence LFSR (newest bit in the LSB).
// Gives both predicted bits of a symbol and the register after shifting them in.
module prbs_step
    import qpsk_pkg::*;
#(
    parameter int             LEN  = LFSR_LEN_DEF,
    parameter logic [LEN-1:0] TAPS = TAPS_DEF
) (
    input  logic [LEN-1:0] shreg,
    output logic [1:0]     pred,
    output logic [LEN-1:0] shreg_next
);

    logic [LEN-1:0] mid;

    always_comb begin
        pred[0]    = ^(shreg & TAPS);
        mid        = {shreg[LEN-2:0], pred[0]};
        pred[1]    = ^(mid & TAPS);
        shreg_next = {mid[LEN-2:0], pred[1]};
    end

endmodule

// File: rtl/qpsk_prbs_checker.sv
// QPSK hard decision plus self-synchronising m-sequence checker with BER counters.
// Define QPSK_CHK_LOSS_DETECT_EN to add windowed loss-of-lock detection.
//
// state  | meaning
// SEARCH | shifting received bits into the local register until it holds a nonzero seed
// VERIFY | free-running local copy, counting consecutive matches toward lock
// LOCK   | counting compared bits and bit errors
module qpsk_prbs_checker
    import qpsk_pkg::*;
#(
    parameter int                  LFSR_LEN   = LFSR_LEN_DEF,
    parameter logic [LFSR_LEN-1:0] TAPS       = TAPS_DEF,
    parameter int                  VERIFY_LEN = 16,
    parameter int                  WIN_LEN    = 64,
    parameter int                  ERR_LIMIT  = 8,
    parameter int                  CNT_W      = 32
) (
    input  logic                CLK_50MHZ,
    input  logic                RST_N,
    input  logic                sym_valid,
    input  logic [SAMPLE_W-1:0] dataI,
    input  logic [SAMPLE_W-1:0] dataQ,
    input  logic                clr_cnt,
    output logic [1:0]          rx_bits,
    output logic                rx_valid,
    output logic                locked,
    output logic [CNT_W-1:0]    bit_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam int SC_W = $clog2(LFSR_LEN + 1);
    localparam int VC_W = $clog2(VERIFY_LEN + 1);

    chk_state_t          state, nx_state;
    logic [LFSR_LEN-1:0] shreg, nx_shreg;
    logic [SC_W-1:0]     srch_cnt, nx_srch;
    logic [VC_W-1:0]     verify_cnt, nx_verify;
    logic [CNT_W-1:0]    nx_bit_cnt, nx_err_cnt;
    logic [1:0]          step_pred;
    logic [LFSR_LEN-1:0] step_next;
    logic                b, p, on_pred;
    logic                unused_lsbs;

`ifdef QPSK_CHK_LOSS_DETECT_EN
    localparam int WC_W = $clog2(WIN_LEN + 1);
    localparam int WE_W = $clog2(ERR_LIMIT + 1);
    logic [WC_W-1:0] win_cnt, nx_win_cnt;
    logic [WE_W-1:0] win_err, nx_win_err;
    logic            loss;
`endif

    // Only the sign of each sample carries the decision.
    assign unused_lsbs = ^{dataI[SAMPLE_W-2:0], dataQ[SAMPLE_W-2:0]};
    assign locked      = (state == LOCK);

    prbs_step #(.LEN(LFSR_LEN), .TAPS(TAPS)) u_step (
        .shreg      (shreg),
        .pred       (step_pred),
        .shreg_next (step_next)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Bits of a symbol are walked in order; the FSM may change state between them.
    always_comb begin
        nx_state   = state;
        nx_shreg   = shreg;
        nx_srch    = srch_cnt;
        nx_verify  = verify_cnt;
        nx_bit_cnt = bit_cnt;
        nx_err_cnt = err_cnt;
        b          = 1'b0;
        p          = 1'b0;
        on_pred    = 1'b0;
`ifdef QPSK_CHK_LOSS_DETECT_EN
        nx_win_cnt = win_cnt;
        nx_win_err = win_err;
        loss       = 1'b0;
`endif
        if (sym_valid) begin
            for (int k = 0; k < 2; k++) begin
                b = (k == 0) ? dataI[SAMPLE_W-1] : dataQ[SAMPLE_W-1];
                if (k == 0)
                    p = step_pred[0];
                else if (on_pred)
                    p = step_pred[1];
                else
                    p = ^(nx_shreg & TAPS);
                case (nx_state)
                    SEARCH: begin
                        nx_shreg = {nx_shreg[LFSR_LEN-2:0], b};
                        if (nx_srch != SC_W'(LFSR_LEN))
                            nx_srch = nx_srch + SC_W'(1);
                        if (nx_srch == SC_W'(LFSR_LEN) && nx_shreg != '0) begin
                            nx_state  = VERIFY;
                            nx_verify = '0;
                        end
                        on_pred = 1'b0;
                    end
                    VERIFY: begin
                        if (b == p) begin
                            nx_shreg  = (k == 1 && on_pred) ? step_next
                                                            : {nx_shreg[LFSR_LEN-2:0], p};
                            nx_verify = nx_verify + VC_W'(1);
                            on_pred   = 1'b1;
                            if (nx_verify == VC_W'(VERIFY_LEN))
                                nx_state = LOCK;
                        end else begin
                            nx_state = SEARCH;
                            nx_srch  = '0;
                            on_pred  = 1'b0;
                        end
                    end
                    LOCK: begin
                        nx_shreg   = (k == 1 && on_pred) ? step_next
                                                         : {nx_shreg[LFSR_LEN-2:0], p};
                        on_pred    = 1'b1;
                        nx_bit_cnt = sat_inc(nx_bit_cnt);
                        if (b != p)
                            nx_err_cnt = sat_inc(nx_err_cnt);
`ifdef QPSK_CHK_LOSS_DETECT_EN
                        nx_win_cnt = nx_win_cnt + WC_W'(1);
                        if (b != p)
                            nx_win_err = nx_win_err + WE_W'(1);
                        if (nx_win_err == WE_W'(ERR_LIMIT))
                            loss = 1'b1;
                        if (nx_win_cnt == WC_W'(WIN_LEN)) begin
                            nx_win_cnt = '0;
                            nx_win_err = '0;
                        end
`endif
                    end
                    default: begin
                        nx_state = SEARCH;
                        nx_srch  = '0;
                    end
                endcase
            end
`ifdef QPSK_CHK_LOSS_DETECT_EN
            // Loss takes effect after the whole symbol has been counted.
            if (loss) begin
                nx_state   = SEARCH;
                nx_srch    = '0;
                nx_win_cnt = '0;
                nx_win_err = '0;
            end
`endif
        end
        if (clr_cnt) begin
            nx_bit_cnt = '0;
            nx_err_cnt = '0;
        end
    end

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state      <= SEARCH;
            shreg      <= '0;
            srch_cnt   <= '0;
            verify_cnt <= '0;
            bit_cnt    <= '0;
            err_cnt    <= '0;
            rx_bits    <= '0;
            rx_valid   <= 1'b0;
`ifdef QPSK_CHK_LOSS_DETECT_EN
            win_cnt    <= '0;
            win_err    <= '0;
`endif
        end else begin
            state      <= nx_state;
            shreg      <= nx_shreg;
            srch_cnt   <= nx_srch;
            verify_cnt <= nx_verify;
            bit_cnt    <= nx_bit_cnt;
            err_cnt    <= nx_err_cnt;
            rx_valid   <= sym_valid;
            if (sym_valid)
                rx_bits <= {dataI[SAMPLE_W-1], dataQ[SAMPLE_W-1]};
`ifdef QPSK_CHK_LOSS_DETECT_EN
            win_cnt    <= nx_win_cnt;
            win_err    <= nx_win_err;
`endif
        end
    end

endmodule

// File: tb/tb_qpsk_prbs_checker.sv
// Self-checking bench for qpsk_prbs_checker: bit-level reference model compared every cycle,
// plus literal expectations for lock point, error counts, clears and reset.
module tb_qpsk_prbs_checker;

    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sym_valid, clr_cnt;
    logic [7:0]  dataI, dataQ;
    logic [1:0]  rx_bits;
    logic        rx_valid, locked;
    logic [31:0] bit_cnt, err_cnt;

    always #5 clk = ~clk;

    qpsk_prbs_checker dut (
        .CLK_50MHZ (clk),
        .RST_N     (rst_n),
        .sym_valid (sym_valid),
        .dataI     (dataI),
        .dataQ     (dataQ),
        .clr_cnt   (clr_cnt),
        .rx_bits   (rx_bits),
        .rx_valid  (rx_valid),
        .locked    (locked),
        .bit_cnt   (bit_cnt),
        .err_cnt   (err_cnt)
    );

    int total = 0;
    int bad   = 0;
    bit seq[31];
    int pos = 0;

    // reference model: mode 0 search, 1 verify, 2 lock; hist holds the local bit history
    int     m_mode, m_cnt, m_ver, m_wbits, m_werr;
    longint m_bits, m_errs;
    bit     m_rxv;
    bit [1:0] m_rxb;
    bit     hist[$];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_ver = 0; m_wbits = 0; m_werr = 0;
        m_bits = 0; m_errs = 0; m_rxv = 0; m_rxb = 2'b00;
        hist.delete();
        repeat (5) hist.push_back(1'b0);
    endtask

    task automatic model_bit(input bit b, inout bit loss);
        bit p, nz;
        p = hist[hist.size()-5] ^ hist[hist.size()-3];
        case (m_mode)
            0: begin
                hist.push_back(b);
                if (m_cnt < 5) m_cnt++;
                nz = 1'b0;
                for (int j = 1; j <= 5; j++) nz |= hist[hist.size()-j];
                if (m_cnt >= 5 && nz) begin m_mode = 1; m_ver = 0; end
            end
            1: begin
                if (b == p) begin
                    hist.push_back(p);
                    m_ver++;
                    if (m_ver == 16) m_mode = 2;
                end else begin
                    m_mode = 0; m_cnt = 0;
                end
            end
            default: begin
                hist.push_back(p);
                if (m_bits < CMAX) m_bits++;
                if (b != p && m_errs < CMAX) m_errs++;
`ifdef QPSK_CHK_LOSS_DETECT_EN
                m_wbits++;
                if (b != p) m_werr++;
                if (m_werr >= 8) loss = 1'b1;
                if (m_wbits == 64) begin m_wbits = 0; m_werr = 0; end
`endif
            end
        endcase
        while (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic model_step(input bit v, input logic [7:0] di, input logic [7:0] dq, input bit c);
        bit loss;
        loss = 1'b0;
        m_rxv = v;
        if (v) begin
            m_rxb = {di[7], dq[7]};
            model_bit(di[7], loss);
            model_bit(dq[7], loss);
            if (loss) begin m_mode = 0; m_cnt = 0; m_wbits = 0; m_werr = 0; end
        end
        if (c) begin m_bits = 0; m_errs = 0; end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step(sym_valid, dataI, dataQ, clr_cnt);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("rx_valid", rx_valid, m_rxv);
            check("rx_bits", rx_bits, m_rxb);
            check("locked", locked, (m_mode == 2));
            check("bit_cnt", bit_cnt, m_bits);
            check("err_cnt", err_cnt, m_errs);
        end
    end

    function automatic logic [7:0] enc(input bit b);
        logic [7:0] v;
        v = 8'($urandom_range(0, 127));
        return b ? ~v : v;
    endfunction

    function automatic bit nxt();
        bit r;
        r = seq[pos];
        pos = (pos + 1) % 31;
        return r;
    endfunction

    task automatic send(input bit bi, input bit bq, input bit clr);
        @(negedge clk);
        sym_valid = 1'b1; dataI = enc(bi); dataQ = enc(bq); clr_cnt = clr;
    endtask

    task automatic send_clean(input bit fi, input bit fq, input bit clr);
        bit bi, bq;
        bi = nxt() ^ fi;
        bq = nxt() ^ fq;
        send(bi, bq, clr);
    endtask

    task automatic idle();
        @(negedge clk);
        sym_valid = 1'b0; dataI = 8'($urandom); dataQ = 8'($urandom); clr_cnt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        sym_valid = 1'b0; clr_cnt = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nsym;
        bit got;
        sym_valid = 1'b0; clr_cnt = 1'b0; dataI = '0; dataQ = '0;
        seq[0] = 1'b1;
        for (int n = 1; n < 5; n++) seq[n] = 1'b0;
        for (int n = 5; n < 31; n++) seq[n] = seq[n-5] ^ seq[n-3];

        #1 rst_n = 1'b0;
        #1;
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_bits", rx_bits, 0);
        check("reset_locked", locked, 0);
        check("reset_bit_cnt", bit_cnt, 0);
        check("reset_err_cnt", err_cnt, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // clean m-sequence: lock on symbol 11, whose second bit is already counted
        pos = $urandom_range(0, 30);
        for (int s = 1; s <= 11; s++) begin
            send_clean(0, 0, 0);
            settle();
            if (s == 10) check("t1_not_locked_yet", locked, 0);
        end
        check("t1_locked", locked, 1);
        check("t1_bit_cnt_at_lock", bit_cnt, 1);
        repeat (20) send_clean(0, 0, 0);
        settle();
        check("t1_bit_cnt_run", bit_cnt, 41);
        check("t1_model_bits", m_bits, 41);
        check("t1_err_cnt", err_cnt, 0);

        // three flipped I decisions
        for (int s = 0; s < 30; s++) send_clean((s == 3 || s == 10 || s == 17), 0, 0);
        settle();
        check("t2_err_cnt", err_cnt, 3);
        check("t2_bit_cnt", bit_cnt, 101);
        check("t2_locked", locked, 1);

        // random mix of idle cycles, bit errors and clears
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 9) < 3) idle();
            else send_clean(($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                            ($urandom_range(0, 49) == 0));
        end

`ifdef QPSK_CHK_LOSS_DETECT_EN
        do_reset();
        pos = $urandom_range(0, 30);
        repeat (11) send_clean(0, 0, 0);
        settle();
        check("t3_locked", locked, 1);
        for (int s = 1; s <= 4; s++) begin
            send_clean(1, 1, 0);
            settle();
            if (s == 3) check("t3_still_locked", locked, 1);
        end
        check("t3_lost", locked, 0);
        check("t3_err_cnt", err_cnt, 8);
        for (int s = 1; s <= 11; s++) begin
            send_clean(0, 0, 0);
            settle();
            if (s == 10) check("t3_not_relocked_yet", locked, 0);
        end
        check("t3_relocked", locked, 1);
        check("t3_err_kept", err_cnt, 8);
`endif

        // all-zero bits never seed the LFSR
        do_reset();
        repeat (40) send(0, 0, 0);
        settle();
        check("t4_locked", locked, 0);
        check("t4_bit_cnt", bit_cnt, 0);
        check("t4_err_cnt", err_cnt, 0);

        // sparse sym_valid: same lock point in symbols
        do_reset();
        pos = $urandom_range(0, 30);
        nsym = 0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            if (c % 3 == 0) begin send_clean(0, 0, 0); nsym++; end
            else idle();
            settle();
            if (locked) got = 1'b1;
        end
        check("t5_lock_symbol", nsym, 11);

        // clear wins over an erroring symbol in the same cycle
        send_clean(1, 0, 1);
        settle();
        check("t6_bit_cnt_clr", bit_cnt, 0);
        check("t6_err_cnt_clr", err_cnt, 0);
        repeat (3) send_clean(0, 0, 0);
        settle();
        check("t6_bit_cnt_after", bit_cnt, 6);

        // asynchronous reset while verifying
        do_reset();
        repeat (4) send_clean(0, 0, 0);
        settle();
        check("t6_pre_unlocked", locked, 0);
        check("t6_pre_rx_valid", rx_valid, 1);
        @(negedge clk);
        sym_valid = 1'b1; dataI = enc(1); dataQ = enc(1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_rx_valid", rx_valid, 0);
        check("t6_async_rx_bits", rx_bits, 0);
        check("t6_async_locked", locked, 0);
        check("t6_async_bit_cnt", bit_cnt, 0);
        check("t6_async_err_cnt", err_cnt, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) idle();
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
